// File: rtl/aes_mixcol_pkg.sv
// aes_mixcol_pkg: GF(2^8) helpers and FSM state type shared by the MixColumns engine.
// Latency: n/a (functions only, purely combinational when used).
// Backpressure: n/a.
package aes_mixcol_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int         NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x, reducing by x^8+x^4+x^3+x+1 when the top bit falls out.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_02(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul_03(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // Inverse coefficients are sums of x^3, x^2, x and 1 terms of the xtime chain.
  function automatic logic [7:0] gf_mul_09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/mix_column_comb.sv
// mix_column_comb: one-column (Inv)MixColumns mixer; mode 0 = forward, 1 = inverse.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
// Ports: mode (1), col_in (32, row r at [8r +: 8]) -> col_out (32, same packing).
// Build option: MIXCOL_FWD_EN builds the forward matrix; otherwise inverse only and mode is ignored.
module mix_column_comb
  import aes_mixcol_pkg::*;
(
  input  logic        mode,
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

`ifndef MIXCOL_FWD_EN
  logic unused_mode;
  assign unused_mode = mode;
`endif

  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [7:0] b0, b1, b2, b3, inv_b;
    // Circulant matrix: row r sees the column rotated by r bytes.
    assign b0 = col_in[8*r +: 8];
    assign b1 = col_in[8*((r+1)%4) +: 8];
    assign b2 = col_in[8*((r+2)%4) +: 8];
    assign b3 = col_in[8*((r+3)%4) +: 8];
    assign inv_b = gf_mul_0e(b0) ^ gf_mul_0b(b1) ^ gf_mul_0d(b2) ^ gf_mul_09(b3);
`ifdef MIXCOL_FWD_EN
    logic [7:0] fwd_b;
    assign fwd_b = gf_mul_02(b0) ^ gf_mul_03(b1) ^ b2 ^ b3;
    assign col_out[8*r +: 8] = mode ? inv_b : fwd_b;
`else
    assign col_out[8*r +: 8] = inv_b;
`endif
  end

endmodule

// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES (Inv)MixColumns over a 128-bit state, COLS_PER_CYCLE columns/clock.
// Latency: 4/COLS_PER_CYCLE + 1 edges from accept to out_valid; output_s is registered.
// Backpressure: result held in DONE until out_valid&&out_ready; in_ready only while IDLE.
// Ports: clk, rst (async, active-high), in_valid/in_ready/mode/input_s, out_valid/out_ready/output_s.
// Build option: MIXCOL_FWD_EN enables the forward matrix and the mode port; otherwise inverse only.
module mix_columns_iter
  import aes_mixcol_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int NUM_COLS_CFG   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [127:0] input_s,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] output_s
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end
  if (NUM_COLS_CFG != NUM_COLS) begin : g_bad_cols
    $error("mix_columns_iter: NUM_COLS is fixed at 4");
  end

  // Step of 4 truncates to 0 in two bits: the counter stays 0, i.e. it has wrapped.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(NUM_COLS - COLS_PER_CYCLE);

  state_t         state_q, state_d;
  logic [1:0]     cnt_q;
  logic [127:0]   in_q;
  logic [127:0]   result_q;
  logic           mode_eff;

`ifdef MIXCOL_FWD_EN
  logic mode_q;
  assign mode_eff = mode_q;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_eff    = 1'b1;
`endif

  logic [2:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
    assign col_idx[g] = {1'b0, cnt_q} + 3'(g);
    mix_column_comb u_mix (
      .mode    (mode_eff),
      .col_in  (in_q[32*col_idx[g] +: 32]),
      .col_out (col_out[g])
    );
  end

  assign in_ready = (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)              state_d = BUSY;
      BUSY:    if (cnt_q == LAST)         state_d = DONE;
      DONE:    if (out_valid && out_ready) state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      in_q      <= '0;
      result_q  <= '0;
      output_s  <= '0;
      out_valid <= 1'b0;
`ifdef MIXCOL_FWD_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          in_q  <= input_s;
          cnt_q <= '0;
`ifdef MIXCOL_FWD_EN
          mode_q <= mode;
`endif
        end
        BUSY: begin
          for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            result_q[32*col_idx[g] +: 32] <= col_out[g];
          end
          cnt_q <= cnt_q + STEP;
        end
        DONE: begin
          // First DONE cycle copies the finished result into the output register.
          if (!out_valid) begin
            out_valid <= 1'b1;
            output_s  <= result_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
module tb_mix_columns_iter;

  localparam logic [127:0] ORIG = {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db};
  localparam logic [127:0] FWD  = {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         mode = 1'b0;
  logic [127:0] input_s = '0;
  logic         out_ready = 1'b0;

  logic         rdy1, vld1, rdy2, vld2, rdy4, vld4;
  logic [127:0] out1, out2, out4;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .mode(mode),
    .input_s(input_s), .out_valid(vld1), .out_ready(out_ready), .output_s(out1));
  mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .mode(mode),
    .input_s(input_s), .out_valid(vld2), .out_ready(out_ready), .output_s(out2));
  mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .mode(mode),
    .input_s(input_s), .out_valid(vld4), .out_ready(out_ready), .output_s(out4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one state on all three engines, then watch up to 8 edges for out_valid.
  task automatic run_latency(input string tag, input logic m, input logic [127:0] d,
                             input logic [127:0] exp);
    int l1, l2, l4;
    l1 = 0; l2 = 0; l4 = 0;
    in_valid = 1'b1; mode = m; input_s = d;
    step();
    in_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      if (l1 == 0) check({tag, "_busy_in_ready"}, rdy1, 1'b0);
      step();
      if (vld1 && l1 == 0) l1 = n;
      if (vld2 && l2 == 0) l2 = n;
      if (vld4 && l4 == 0) l4 = n;
    end
    check({tag, "_lat_cpc1"}, l1, 5);
    check({tag, "_lat_cpc2"}, l2, 3);
    check({tag, "_lat_cpc4"}, l4, 2);
    check({tag, "_data_cpc1"}, out1, exp);
    check({tag, "_data_cpc2"}, out2, exp);
    check({tag, "_data_cpc4"}, out4, exp);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, vld1, 1'b0);
    check({tag, "_drain_ready"}, rdy1, 1'b1);
  endtask

  initial begin
    logic [127:0] held;
    int lat;

    // Reset state
    step(); step();
    check("rst_in_ready", rdy1, 1'b1);
    check("rst_out_valid", vld1, 1'b0);
    check("rst_output_s", out1, 128'h0);
    rst = 1'b0;
    step();

    // Forward FIPS vector; without the forward build mode=0 is ignored and the inverse applies.
`ifdef MIXCOL_FWD_EN
    run_latency("fwd", 1'b0, ORIG, FWD);
`else
    run_latency("mode_ignored", 1'b0, FWD, ORIG);
`endif
    drain("t1");

    // Inverse of the forward result, then backpressure while DONE
    run_latency("inv", 1'b1, FWD, ORIG);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; input_s = ~ORIG;
      step();
      check("bp_valid", vld1, 1'b1);
      check("bp_data", out1, ORIG);
      check("bp_no_accept", rdy1, 1'b0);
    end
    in_valid = 1'b0;
    drain("bp");
    step();
    check("bp_idle_stays", vld1, 1'b0);

    // Input hold: operands scrambled every cycle after accept; out_ready high during BUSY
    in_valid = 1'b1; mode = 1'b1; input_s = FWD;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    lat = 0; held = '0;
    for (int n = 1; n <= 8; n++) begin
      mode = ~mode;
      input_s = {$urandom, $urandom, $urandom, $urandom};
      step();
      if (vld1 && lat == 0) begin
        lat = n;
        held = out1;
      end
    end
    out_ready = 1'b0;
    check("hold_latency", lat, 5);
    check("hold_data", held, ORIG);
    check("hold_drained", vld1, 1'b0);

    // Reset during BUSY cycle 2
    in_valid = 1'b1; mode = 1'b1; input_s = FWD;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("midrst_valid", vld1, 1'b0);
    check("midrst_output", out1, 128'h0);
    check("midrst_ready", rdy1, 1'b1);
    #2;
    rst = 1'b0;
    step();
    run_latency("post_rst", 1'b1, FWD, ORIG);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
